dmem_waitstate: RTL



---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_waitstate.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory wait-state responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned WAITW = 4;

    function automatic logic is_status(input logic [31:0] adr, input logic [31:0] status_addr);
        return adr == status_addr;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-to-memory data bus: request/response handshake with address and data.
interface dmem_if;

    logic        req;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;

    modport master (
        output req, memwrite, dataadr, writedata,
        input  readdata, ready
    );

    modport slave (
        input  req, memwrite, dataadr, writedata,
        output readdata, ready
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word-addressed RAM: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_waitstate.sv
// Data-memory responder: fixed wait states per access, word RAM, and a
// memory-mapped status port that records test done/pass plus access errors.
module dmem_waitstate
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] STATUS_ADDR = 32'd84,
    parameter logic [31:0] PASS_VALUE  = 32'd8781
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus,
    output logic  done,
    output logic  pass,
    output logic  err
);

    localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
    localparam logic [WAITW-1:0] WAIT_INIT = WAITW'(WAIT_CYCLES);

    dmem_state_t      state, state_next;
    logic [WAITW-1:0] cnt, cnt_next;
    logic             capture, go_resp;

    logic [31:0] adr_q, wdata_q, rdata_q;
    logic        write_q;

    logic [31:0] adr_a, wdata_a, ram_rdata, load_val;
    logic        write_a, status_hit, bad, ram_we;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        go_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    capture  = 1'b1;
                    cnt_next = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - WAITW'(1);
                if (cnt == WAITW'(1)) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access completes on its capture edge, so the
    // live bus is used while IDLE and the latched copy once the FSM has moved on.
    assign adr_a   = (state == IDLE) ? bus.dataadr   : adr_q;
    assign wdata_a = (state == IDLE) ? bus.writedata : wdata_q;
    assign write_a = (state == IDLE) ? bus.memwrite  : write_q;

    assign status_hit = is_status(adr_a, STATUS_ADDR);
    assign bad        = !status_hit &&
                        ((adr_a[1:0] != 2'b00) || ({2'b00, adr_a[31:2]} >= DEPTH_WORDS));
    // Gating by reset keeps an abandoned access from writing while reset is held.
    assign ram_we     = go_resp && reset && write_a && !status_hit && !bad;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (adr_a[AW+1:2]),
        .wdata(wdata_a),
        .rdata(ram_rdata)
    );

    always_comb begin
        load_val = ram_rdata;
        if (status_hit) begin
            load_val = {30'b0, pass, done};
        end else if (bad) begin
            load_val = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rdata_q <= '0;
            if (capture) begin
                adr_q   <= bus.dataadr;
                wdata_q <= bus.writedata;
                write_q <= bus.memwrite;
            end
            if (go_resp) begin
                if (!write_a) begin
                    rdata_q <= load_val;
                end
                if (bad) begin
                    err <= 1'b1;
                end
                if (write_a && status_hit) begin
                    done <= 1'b1;
                    if (wdata_a == PASS_VALUE) begin
                        pass <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ready    = (state == RESP);
    assign bus.readdata = rdata_q;

endmodule
